fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/mips_pkg.sv | 34 +++
 rtl/fetch_unit_flopenrc.sv | 31 +++
 rtl/fetch_unit.sv | 130 +++++++++++++
 tb/tb_fetch_unit.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types for the MIPS fetch stage: FSM states,
// the IF/ID bundle, the NOP bubble word and the redirect target helper.
package mips_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DROP  = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pcplus4;
        logic        valid;
    } if_id_t;

    localparam int IF_ID_W = $bits(if_id_t);

    // Jump wins over branch; targets are always word aligned.
    function automatic logic [31:0] redirect_target(
        input logic        jump,
        input logic [31:0] pcj,
        input logic [31:0] pcb
    );
        logic [31:0] t;
        t = jump ? pcj : pcb;
        return {t[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_flopenrc.sv
// Resettable register with enable and synchronous clear.
// Used as the IF/ID pipeline register.
module flopenrc #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;

    // Hold when disabled; clear takes priority over load when enabled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q <= '0;
        end else if (en) begin
            if (clear) begin
                q_q <= '0;
            end else begin
                q_q <= d;
            end
        end
    end

    assign q = q_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem request FSM,
// one-entry hold buffer for stalled responses, and the IF/ID register.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stallD,
    input  logic        pcsrcD,
    input  logic        jumpD,
    input  logic [31:0] pcbranchD,
    input  logic [31:0] pcjumpD,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instrD,
    output logic [31:0] pcplus4D,
    output logic        validD,
    output logic [5:0]  opD,
    output logic [5:0]  functD
);

    fetch_state_t state_q;
    logic [31:0]  pc_q;
    logic [31:0]  hold_q;

    logic         redirect;
    logic [31:0]  target;
    logic [31:0]  pc_plus4;
    logic         deliver;
    logic         ifid_en;
    logic         ifid_clr;
    if_id_t       ifid_d;
    if_id_t       ifid_q;

    // Redirect, target and which word (if any) reaches IF/ID this cycle.
    always_comb begin
        redirect = validD & ~stallD & (jumpD | pcsrcD);
        target   = redirect_target(jumpD, pcjumpD, pcbranchD);
        pc_plus4 = pc_q + PC_STEP;
        deliver  = 1'b0;
        ifid_d   = '0;
        if (!stallD && !redirect) begin
            if (state_q == WAIT && imem_rvalid) begin
                deliver = 1'b1;
            end else if (state_q == HOLD) begin
                deliver = 1'b1;
            end
        end
        ifid_d.instr   = (state_q == HOLD) ? hold_q : imem_rdata;
        ifid_d.pcplus4 = pc_plus4;
        ifid_d.valid   = 1'b1;
        ifid_en        = ~stallD;
        ifid_clr       = redirect | ~deliver;
    end

    // Request FSM: PC update, outstanding-request tracking, hold buffer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            hold_q  <= NOP_INSTR;
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (redirect) begin
                        pc_q <= target;
                    end else begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (redirect) begin
                        pc_q    <= target;
                        state_q <= imem_rvalid ? FETCH : DROP;
                    end else if (imem_rvalid) begin
                        if (stallD) begin
                            hold_q  <= imem_rdata;
                            state_q <= HOLD;
                        end else begin
                            pc_q    <= pc_plus4;
                            state_q <= FETCH;
                        end
                    end
                end
                HOLD: begin
                    if (!stallD) begin
                        pc_q    <= redirect ? target : pc_plus4;
                        hold_q  <= NOP_INSTR;
                        state_q <= FETCH;
                    end
                end
                DROP: begin
                    if (redirect) begin
                        pc_q <= target;
                    end
                    if (imem_rvalid) begin
                        state_q <= FETCH;
                    end
                end
                default: begin
                    state_q <= FETCH;
                end
            endcase
        end
    end

    flopenrc #(
        .WIDTH (IF_ID_W)
    ) u_ifid (
        .clk   (clk),
        .reset (reset),
        .en    (ifid_en),
        .clear (ifid_clr),
        .d     (ifid_d),
        .q     (ifid_q)
    );

    assign imem_req  = reset & (state_q == FETCH) & ~redirect;
    assign imem_addr = pc_q;
    assign instrD    = ifid_q.instr;
    assign pcplus4D  = ifid_q.pcplus4;
    assign validD    = ifid_q.valid;
    assign opD       = ifid_q.instr[31:26];
    assign functD    = ifid_q.instr[5:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, stall/hold,
// jump into DROP, jump/branch priority, mid-request reset, PC wrap.
module tb_fetch_unit;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        stallD, pcsrcD, jumpD;
    logic [31:0] pcbranchD, pcjumpD;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    logic        imem_req, imem_req2;
    logic [31:0] imem_addr, imem_addr2;
    logic [31:0] instrD, instrD2;
    logic [31:0] pcplus4D, pcplus4D2;
    logic        validD, validD2;
    logic [5:0]  opD, opD2, functD, functD2;

    int nvec = 0;
    int nerr = 0;

    localparam logic [31:0] I0 = 32'h2001_0005;
    localparam logic [31:0] I1 = 32'h0022_1820;
    localparam logic [31:0] I2 = 32'h8C64_0008;
    localparam logic [31:0] I3 = 32'hAC85_000C;
    localparam logic [31:0] I4 = 32'h1000_FFFF;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .stallD(stallD), .pcsrcD(pcsrcD),
        .jumpD(jumpD), .pcbranchD(pcbranchD), .pcjumpD(pcjumpD),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instrD(instrD), .pcplus4D(pcplus4D), .validD(validD),
        .opD(opD), .functD(functD)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .reset(reset), .stallD(stallD), .pcsrcD(pcsrcD),
        .jumpD(jumpD), .pcbranchD(pcbranchD), .pcjumpD(pcjumpD),
        .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instrD(instrD2), .pcplus4D(pcplus4D2), .validD(validD2),
        .opD(opD2), .functD(functD2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stallD = 0; pcsrcD = 0; jumpD = 0;
        pcbranchD = 0; pcjumpD = 0;
        imem_rvalid = 0; imem_rdata = 0;
    endtask

    task automatic test_reset();
        reset = 0;
        idle_inputs();
        step(); step();
        #1;
        nvec++;
        if (imem_req !== 1'b0) begin
            nerr++; $display("FAIL rst_req got %0b want 0", imem_req);
        end
        nvec++;
        if ({validD, instrD, pcplus4D} !== 65'h0) begin
            nerr++; $display("FAIL rst_ifid got %0b %h %h want 0 0 0", validD, instrD, pcplus4D);
        end
        nvec++;
        if (imem_addr !== 32'h0 || imem_addr2 !== 32'hFFFF_FFFC) begin
            nerr++; $display("FAIL rst_pc got %h %h want 00000000 fffffffc", imem_addr, imem_addr2);
        end
        nvec++;
        if (dut.state_q !== FETCH) begin
            nerr++; $display("FAIL rst_state got %0d want %0d", dut.state_q, FETCH);
        end
        reset = 1;
        #1;
    endtask

    task automatic test_sequential();
        nvec++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            nerr++; $display("FAIL seq_req0 got %0b %h want 1 00000000", imem_req, imem_addr);
        end
        step();
        imem_rvalid = 1; imem_rdata = I0;
        #1;
        nvec++;
        if (imem_req !== 1'b0 || dut.state_q !== WAIT) begin
            nerr++; $display("FAIL seq_wait got %0b %0d want 0 %0d", imem_req, dut.state_q, WAIT);
        end
        step();
        imem_rvalid = 0;
        #1;
        nvec++;
        if (validD !== 1'b1 || instrD !== I0 || pcplus4D !== 32'h4) begin
            nerr++; $display("FAIL seq_d0 got %0b %h %h want 1 %h 00000004", validD, instrD, pcplus4D, I0);
        end
        nvec++;
        if (opD !== 6'h08 || functD !== 6'h05) begin
            nerr++; $display("FAIL seq_fields got %h %h want 08 05", opD, functD);
        end
        nvec++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
            nerr++; $display("FAIL seq_req1 got %0b %h want 1 00000004", imem_req, imem_addr);
        end
        step();
        imem_rvalid = 1; imem_rdata = I1;
        #1;
        nvec++;
        if (validD !== 1'b0 || instrD !== NOP_INSTR) begin
            nerr++; $display("FAIL seq_bubble got %0b %h want 0 00000000", validD, instrD);
        end
        step();
        imem_rvalid = 0;
        #1;
        nvec++;
        if (validD !== 1'b1 || instrD !== I1 || pcplus4D !== 32'h8) begin
            nerr++; $display("FAIL seq_d1 got %0b %h %h want 1 %h 00000008", validD, instrD, pcplus4D, I1);
        end
        nvec++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
            nerr++; $display("FAIL seq_req2 got %0b %h want 1 00000008", imem_req, imem_addr);
        end
    endtask

    task automatic test_stall_hold();
        stallD = 1;
        step();
        imem_rvalid = 1; imem_rdata = I2;
        #1;
        nvec++;
        if (validD !== 1'b1 || instrD !== I1 || imem_req !== 1'b0) begin
            nerr++; $display("FAIL stall_wait got %0b %h %0b want 1 %h 0", validD, instrD, imem_req, I1);
        end
        step();
        imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF;
        #1;
        nvec++;
        if (dut.state_q !== HOLD || instrD !== I1 || pcplus4D !== 32'h8) begin
            nerr++; $display("FAIL stall_hold got %0d %h %h want %0d %h 00000008", dut.state_q, instrD, pcplus4D, HOLD, I1);
        end
        step();
        imem_rvalid = 0; imem_rdata = 0;
        stallD = 0;
        #1;
        nvec++;
        if (dut.state_q !== HOLD || instrD !== I1 || imem_req !== 1'b0) begin
            nerr++; $display("FAIL stall_frozen got %0d %h %0b want %0d %h 0", dut.state_q, instrD, imem_req, HOLD, I1);
        end
        step();
        nvec++;
        if (validD !== 1'b1 || instrD !== I2 || pcplus4D !== 32'hC) begin
            nerr++; $display("FAIL stall_release got %0b %h %h want 1 %h 0000000c", validD, instrD, pcplus4D, I2);
        end
        nvec++;
        if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin
            nerr++; $display("FAIL stall_nextpc got %0b %h want 1 0000000c", imem_req, imem_addr);
        end
    endtask

    task automatic test_jump_drop();
        stallD = 1;
        step();
        stallD = 0; jumpD = 1; pcjumpD = 32'h0000_0103;
        #1;
        nvec++;
        if (imem_req !== 1'b0 || validD !== 1'b1 || dut.state_q !== WAIT) begin
            nerr++; $display("FAIL jmp_setup got %0b %0b %0d want 0 1 %0d", imem_req, validD, dut.state_q, WAIT);
        end
        step();
        jumpD = 0; pcjumpD = 0;
        #1;
        nvec++;
        if (dut.state_q !== DROP || imem_addr !== 32'h100 || imem_req !== 1'b0) begin
            nerr++; $display("FAIL jmp_drop got %0d %h %0b want %0d 00000100 0", dut.state_q, imem_addr, imem_req, DROP);
        end
        nvec++;
        if ({validD, instrD, pcplus4D} !== 65'h0) begin
            nerr++; $display("FAIL jmp_bubble got %0b %h %h want 0 0 0", validD, instrD, pcplus4D);
        end
        imem_rvalid = 1; imem_rdata = 32'hBAD0_0001;
        step();
        imem_rvalid = 0; imem_rdata = 0;
        #1;
        nvec++;
        if (dut.state_q !== FETCH || validD !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            nerr++; $display("FAIL jmp_stale got %0d %0b %0b %h want %0d 0 1 00000100", dut.state_q, validD, imem_req, imem_addr, FETCH);
        end
        step();
        imem_rvalid = 1; imem_rdata = I3;
        step();
        imem_rvalid = 0;
        #1;
        nvec++;
        if (validD !== 1'b1 || instrD !== I3 || pcplus4D !== 32'h104 || imem_addr !== 32'h104) begin
            nerr++; $display("FAIL jmp_target got %0b %h %h %h want 1 %h 00000104 00000104", validD, instrD, pcplus4D, imem_addr, I3);
        end
    endtask

    task automatic test_priority();
        pcsrcD = 1; jumpD = 1;
        pcbranchD = 32'h40; pcjumpD = 32'h80;
        #1;
        nvec++;
        if (imem_req !== 1'b0) begin
            nerr++; $display("FAIL prio_noreq got %0b want 0", imem_req);
        end
        step();
        pcsrcD = 0; jumpD = 0; pcbranchD = 0; pcjumpD = 0;
        #1;
        nvec++;
        if (imem_addr !== 32'h80 || imem_req !== 1'b1 || validD !== 1'b0) begin
            nerr++; $display("FAIL prio_target got %h %0b %0b want 00000080 1 0", imem_addr, imem_req, validD);
        end
    endtask

    task automatic test_reset_mid();
        step();
        reset = 0; imem_rvalid = 1; imem_rdata = 32'h1234_5678;
        #1;
        nvec++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h0 || validD !== 1'b0) begin
            nerr++; $display("FAIL rmid_async got %0b %h %0b want 0 00000000 0", imem_req, imem_addr, validD);
        end
        step();
        reset = 1;
        #1;
        nvec++;
        if ({validD, instrD, pcplus4D} !== 65'h0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            nerr++; $display("FAIL rmid_release got %0b %h %h %0b %h want 0 0 0 1 0", validD, instrD, pcplus4D, imem_req, imem_addr);
        end
        step();
        imem_rdata = I4;
        step();
        imem_rvalid = 0;
        #1;
        nvec++;
        if (validD !== 1'b1 || instrD !== I4 || pcplus4D !== 32'h4) begin
            nerr++; $display("FAIL rmid_refetch got %0b %h %h want 1 %h 00000004", validD, instrD, pcplus4D, I4);
        end
    endtask

    task automatic test_wrap();
        reset = 0;
        idle_inputs();
        step();
        reset = 1;
        #1;
        nvec++;
        if (imem_req2 !== 1'b1 || imem_addr2 !== 32'hFFFF_FFFC) begin
            nerr++; $display("FAIL wrap_first got %0b %h want 1 fffffffc", imem_req2, imem_addr2);
        end
        step();
        imem_rvalid = 1; imem_rdata = I0;
        step();
        imem_rvalid = 0;
        #1;
        nvec++;
        if (validD2 !== 1'b1 || instrD2 !== I0 || pcplus4D2 !== 32'h0) begin
            nerr++; $display("FAIL wrap_ifid got %0b %h %h want 1 %h 00000000", validD2, instrD2, pcplus4D2, I0);
        end
        nvec++;
        if (imem_req2 !== 1'b1 || imem_addr2 !== 32'h0) begin
            nerr++; $display("FAIL wrap_next got %0b %h want 1 00000000", imem_req2, imem_addr2);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall_hold();
        test_jump_drop();
        test_priority();
        test_reset_mid();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
